// File: rtl/regfile_scoreboard_if.sv
// Decoder/ALU-facing bus of regfile_scoreboard: write, pend, fill and read ports.
// The master modport drives requests and the slave modport (the register bank) drives read data and status.
interface regfile_scoreboard_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
);
  logic              load_en;
  logic [ADDR_W-1:0] dest_sel;
  logic [WIDTH-1:0]  d;
  logic              pend_req;
  logic [ADDR_W-1:0] pend_sel;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_sel;
  logic [WIDTH-1:0]  fill_data;
  logic [ADDR_W-1:0] a_sel;
  logic [ADDR_W-1:0] b_sel;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              a_busy;
  logic              b_busy;
  logic [ADDR_W:0]   busy_cnt;
  logic              fill_err;

  modport master (
    output load_en, dest_sel, d, pend_req, pend_sel,
    output fill_valid, fill_sel, fill_data, a_sel, b_sel,
    input  A, B, a_busy, b_busy, busy_cnt, fill_err
  );

  modport slave (
    input  load_en, dest_sel, d, pend_req, pend_sel,
    input  fill_valid, fill_sel, fill_data, a_sel, b_sel,
    output A, B, a_busy, b_busy, busy_cnt, fill_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register bank with two read ports and a per-register busy scoreboard for multi-cycle fills.
// Define REGFILE_BYPASS_EN to forward same-cycle writes and busy changes onto the read ports.
module regfile_scoreboard #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [ADDR_W:0]  busy_cnt_q;
  logic [ADDR_W:0]  busy_cnt_d;
  logic             fill_err_q;
  logic             fill_err_d;
  logic             fill_hit;
  logic             load_fill_clash;

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Next state: load beats fill on data, pend beats both clears on busy.
  always_comb begin
    regs_d          = regs_q;
    busy_d          = busy_q;
    load_fill_clash = bus.load_en && (bus.dest_sel == bus.fill_sel);
    fill_hit        = bus.fill_valid && busy_q[bus.fill_sel];

    if (fill_hit) begin
      busy_d[bus.fill_sel] = 1'b0;
      if (!load_fill_clash) begin
        regs_d[bus.fill_sel] = bus.fill_data;
      end else begin
      end
    end else begin
    end

    if (bus.load_en) begin
      regs_d[bus.dest_sel] = bus.d;
      busy_d[bus.dest_sel] = 1'b0;
    end else begin
    end

    if (bus.pend_req) begin
      busy_d[bus.pend_sel] = 1'b1;
    end else begin
    end

    // A fill shadowed by a same-register load is dropped silently.
    fill_err_d = bus.fill_valid && !busy_q[bus.fill_sel] && !load_fill_clash;
    busy_cnt_d = popcount(busy_d);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
      fill_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      fill_err_q <= fill_err_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign bus.A      = regs_d[bus.a_sel];
  assign bus.B      = regs_d[bus.b_sel];
  assign bus.a_busy = busy_d[bus.a_sel];
  assign bus.b_busy = busy_d[bus.b_sel];
`else
  assign bus.A      = regs_q[bus.a_sel];
  assign bus.B      = regs_q[bus.b_sel];
  assign bus.a_busy = busy_q[bus.a_sel];
  assign bus.b_busy = busy_q[bus.b_sel];
`endif
  assign bus.busy_cnt = busy_cnt_q;
  assign bus.fill_err = fill_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model of the register bank.
module tb_regfile_scoreboard;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_scoreboard_if #(.WIDTH(4), .ADDR_W(2)) bus ();

  regfile_scoreboard #(.WIDTH(4), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state and its next-state image for the inputs currently applied.
  int mregs [4];
  bit mbusy [4];
  int mcnt;
  bit merr;
  int nregs [4];
  bit nbusy [4];
  int ncnt;
  bit nerr;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_next();
    int  ds, fs, ps;
    bit  hit;
    ds = int'(bus.dest_sel);
    fs = int'(bus.fill_sel);
    ps = int'(bus.pend_sel);
    nregs = mregs;
    nbusy = mbusy;
    hit = bus.fill_valid && mbusy[fs];
    if (hit) begin
      nbusy[fs] = 1'b0;
      nregs[fs] = int'(bus.fill_data);
    end
    if (bus.load_en) begin
      nregs[ds] = int'(bus.d);
      nbusy[ds] = 1'b0;
    end
    if (bus.pend_req) nbusy[ps] = 1'b1;
    nerr = bus.fill_valid && !mbusy[fs] && !(bus.load_en && ds == fs);
    ncnt = 0;
    foreach (nbusy[i]) ncnt += int'(nbusy[i]);
  endtask

  task automatic check_outs();
    int as, bs;
    as = int'(bus.a_sel);
    bs = int'(bus.b_sel);
    model_next();
`ifdef REGFILE_BYPASS_EN
    check_eq("A", int'(bus.A), nregs[as]);
    check_eq("B", int'(bus.B), nregs[bs]);
    check_eq("a_busy", int'(bus.a_busy), int'(nbusy[as]));
    check_eq("b_busy", int'(bus.b_busy), int'(nbusy[bs]));
`else
    check_eq("A", int'(bus.A), mregs[as]);
    check_eq("B", int'(bus.B), mregs[bs]);
    check_eq("a_busy", int'(bus.a_busy), int'(mbusy[as]));
    check_eq("b_busy", int'(bus.b_busy), int'(mbusy[bs]));
`endif
    check_eq("busy_cnt", int'(bus.busy_cnt), mcnt);
    check_eq("fill_err", int'(bus.fill_err), int'(merr));
  endtask

  // One clock: check outputs for the applied inputs, then advance DUT and model.
  task automatic tick(input bit do_check = 1'b1);
    #1;
    if (do_check) check_outs();
    model_next();
    @(posedge clk);
    if (rst) begin
      foreach (mregs[i]) begin
        mregs[i] = 0;
        mbusy[i] = 1'b0;
      end
      mcnt = 0;
      merr = 1'b0;
    end else begin
      mregs = nregs;
      mbusy = nbusy;
      mcnt  = ncnt;
      merr  = nerr;
    end
    #1;
  endtask

  task automatic idle();
    rst            = 1'b0;
    bus.load_en    = 1'b0;
    bus.pend_req   = 1'b0;
    bus.fill_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    foreach (mregs[i]) begin
      mregs[i] = 0;
      mbusy[i] = 1'b0;
    end
    mcnt = 0;
    merr = 1'b0;
    bus.dest_sel = 2'd0; bus.d = 4'd0; bus.pend_sel = 2'd0;
    bus.fill_sel = 2'd0; bus.fill_data = 4'd0;
    bus.a_sel = 2'd0; bus.b_sel = 2'd1;
    idle();

    // Reset overrides a simultaneous write.
    rst = 1'b1; bus.load_en = 1'b1; bus.dest_sel = 2'd2; bus.d = 4'd5;
    tick(1'b0);
    idle(); bus.a_sel = 2'd2; bus.b_sel = 2'd2;
    #1;
    check_eq("reset_A", int'(bus.A), 0);
    check_eq("reset_B", int'(bus.B), 0);
    check_eq("reset_cnt", int'(bus.busy_cnt), 0);
    check_eq("reset_err", int'(bus.fill_err), 0);

    // Immediate writes, read back on both ports.
    bus.load_en = 1'b1; bus.dest_sel = 2'd2; bus.d = 4'hA;
`ifdef REGFILE_BYPASS_EN
    #1;
    check_eq("bypass_A", int'(bus.A), 10);
`endif
    tick();
    bus.dest_sel = 2'd3; bus.d = 4'h5;
    tick();
    idle(); bus.a_sel = 2'd2; bus.b_sel = 2'd3;
    #1;
    check_eq("wr_A", int'(bus.A), 10);
    check_eq("wr_B", int'(bus.B), 5);

    // Pend then fill three cycles later.
    bus.pend_req = 1'b1; bus.pend_sel = 2'd1;
    tick();
    idle(); bus.a_sel = 2'd1;
    #1;
    check_eq("pend_a_busy", int'(bus.a_busy), 1);
    check_eq("pend_cnt", int'(bus.busy_cnt), 1);
    tick(); tick();
    bus.fill_valid = 1'b1; bus.fill_sel = 2'd1; bus.fill_data = 4'h7;
    tick();
    idle();
    #1;
    check_eq("fill_A", int'(bus.A), 7);
    check_eq("fill_a_busy", int'(bus.a_busy), 0);
    check_eq("fill_cnt", int'(bus.busy_cnt), 0);
    check_eq("fill_err_clean", int'(bus.fill_err), 0);

    // Spurious fill to an idle register.
    bus.fill_valid = 1'b1; bus.fill_sel = 2'd0; bus.fill_data = 4'hF;
    tick();
    idle(); bus.a_sel = 2'd0;
    #1;
    check_eq("spur_err", int'(bus.fill_err), 1);
    check_eq("spur_A", int'(bus.A), 0);
    tick();
    check_eq("spur_err_pulse", int'(bus.fill_err), 0);

    // Load beats fill on the same busy register.
    bus.pend_req = 1'b1; bus.pend_sel = 2'd2;
    tick();
    idle();
    bus.load_en = 1'b1; bus.dest_sel = 2'd2; bus.d = 4'h3;
    bus.fill_valid = 1'b1; bus.fill_sel = 2'd2; bus.fill_data = 4'hC;
    tick();
    idle(); bus.a_sel = 2'd2;
    #1;
    check_eq("clash_A", int'(bus.A), 3);
    check_eq("clash_busy", int'(bus.a_busy), 0);
    check_eq("clash_err", int'(bus.fill_err), 0);

    // Pend and fill together on a busy register: data lands, busy stays.
    bus.pend_req = 1'b1; bus.pend_sel = 2'd1;
    tick();
    bus.fill_valid = 1'b1; bus.fill_sel = 2'd1; bus.fill_data = 4'h9;
    tick();
    idle(); bus.a_sel = 2'd1;
    #1;
    check_eq("pf_A", int'(bus.A), 9);
    check_eq("pf_busy", int'(bus.a_busy), 1);
    check_eq("pf_cnt", int'(bus.busy_cnt), 1);
    bus.fill_valid = 1'b1; bus.fill_sel = 2'd1; bus.fill_data = 4'h1;
    tick();
    idle();

    // Fill up the scoreboard and drain it in reverse.
    for (int i = 0; i < 4; i++) begin
      bus.pend_req = 1'b1; bus.pend_sel = 2'(i);
      tick();
      idle();
      #1;
      check_eq("full_cnt_up", int'(bus.busy_cnt), i + 1);
    end
    for (int i = 3; i >= 0; i--) begin
      bus.fill_valid = 1'b1; bus.fill_sel = 2'(i); bus.fill_data = 4'(i + 4);
      tick();
      idle();
      #1;
      check_eq("full_cnt_down", int'(bus.busy_cnt), i);
    end
    bus.pend_req = 1'b1; bus.pend_sel = 2'd0;
    tick();
    bus.pend_sel = 2'd3;
    tick();
    idle(); rst = 1'b1;
    tick();
    idle();
    #1;
    check_eq("mid_reset_cnt", int'(bus.busy_cnt), 0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus.load_en    = ($urandom_range(0, 3) == 0);
      bus.dest_sel   = 2'($urandom_range(0, 3));
      bus.d          = 4'($urandom_range(0, 15));
      bus.pend_req   = ($urandom_range(0, 2) == 0);
      bus.pend_sel   = 2'($urandom_range(0, 3));
      bus.fill_valid = ($urandom_range(0, 2) == 0);
      bus.fill_sel   = 2'($urandom_range(0, 3));
      bus.fill_data  = 4'($urandom_range(0, 15));
      bus.a_sel      = 2'($urandom_range(0, 3));
      bus.b_sel      = 2'($urandom_range(0, 3));
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
